// File: rtl/tl_ul_buffer_param.sv
// ----------------------------------------------------------------------------
// tl_ul_buffer_param
//   TileLink-UL channel buffer placed between a TL master port and a TL slave
//   port. It holds an independent A-channel (request) FIFO and D-channel
//   (response) FIFO. Each channel has its own depth (0 = wire), its own FLOW
//   mode (bypass when empty) and its own PIPE mode (accept when full while the
//   head leaves). The beat contents are opaque and pass through unchanged.
//
// Ports
//   clock, reset_n           : clock (rising edge), async active-low reset
//   a_in_*  / a_out_*        : A channel, master side in, slave side out
//   d_in_*  / d_out_*        : D channel, slave side in, master side out
//   a_count / d_count        : current occupancy of each queue
// ----------------------------------------------------------------------------

// Generic valid/ready FIFO used for both channels.
module tl_ul_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int PIPE  = 0,
    parameter int CW    = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [W-1:0]  i_in_bits,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [W-1:0]  o_out_bits,
    output logic [CW-1:0] o_count
);

    if (DEPTH == 0) begin : g_wire
        // Pure pass-through: no storage, FLOW/PIPE have nothing to act on.
        assign o_out_valid = i_in_valid;
        assign o_out_bits  = i_in_bits;
        assign o_in_ready  = i_out_ready;
        assign o_count     = '0;
    end else begin : g_fifo
        localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam bit FLOW_EN = (FLOW != 0);
        localparam bit PIPE_EN = (PIPE != 0);

        logic [W-1:0]  r_mem [DEPTH];
        logic [PW-1:0] r_enq_ptr;
        logic [PW-1:0] r_deq_ptr;
        logic [CW-1:0] r_count;

        logic w_empty;
        logic w_full;
        logic w_bypass;
        logic w_enq;
        logic w_deq;

        // Wrap explicitly so non-power-of-2 depths cycle through 0..DEPTH-1.
        function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
            return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
        endfunction

        assign w_empty = (r_count == '0);
        assign w_full  = (r_count == CW'(DEPTH));

        // A beat that arrives at an empty FLOW queue and is taken at once
        // never touches storage.
        assign w_bypass = FLOW_EN && w_empty && i_in_valid && i_out_ready;

        assign o_out_valid = !w_empty || (FLOW_EN && i_in_valid);
        assign o_out_bits  = (FLOW_EN && w_empty) ? i_in_bits : r_mem[r_deq_ptr];
        assign o_in_ready  = !w_full || (PIPE_EN && i_out_ready);
        assign o_count     = r_count;

        assign w_enq = i_in_valid && o_in_ready && !w_bypass;
        assign w_deq = o_out_valid && i_out_ready && !w_bypass;

        // NOTE: storage is not reset; the count guarantees no stale entry is
        // ever presented, and leaving it unreset keeps it a plain RAM array.
        always_ff @(posedge clock) begin
            if (w_enq) begin
                r_mem[r_enq_ptr] <= i_in_bits;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_enq_ptr <= '0;
                r_deq_ptr <= '0;
                r_count   <= '0;
            end else begin
                if (w_enq) begin
                    r_enq_ptr <= f_next(r_enq_ptr);
                end
                if (w_deq) begin
                    r_deq_ptr <= f_next(r_deq_ptr);
                end
                if (w_enq && !w_deq) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_enq && w_deq) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule

module tl_ul_buffer_param #(
    parameter int AW      = 14,
    parameter int DW      = 32,
    parameter int SRCW    = 4,
    parameter int SZW     = 3,
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int A_FLOW  = 0,
    parameter int D_FLOW  = 0,
    parameter int A_PIPE  = 0,
    parameter int D_PIPE  = 0
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic                                          a_in_valid,
    output logic                                          a_in_ready,
    input  logic [7+SZW+SRCW+AW+DW/8+DW-1:0]              a_in_bits,
    output logic                                          a_out_valid,
    input  logic                                          a_out_ready,
    output logic [7+SZW+SRCW+AW+DW/8+DW-1:0]              a_out_bits,
    input  logic                                          d_in_valid,
    output logic                                          d_in_ready,
    input  logic [7+SZW+SRCW+DW-1:0]                      d_in_bits,
    output logic                                          d_out_valid,
    input  logic                                          d_out_ready,
    output logic [7+SZW+SRCW+DW-1:0]                      d_out_bits,
    output logic [((A_DEPTH > 0) ? $clog2(A_DEPTH+1) : 1)-1:0] a_count,
    output logic [((D_DEPTH > 0) ? $clog2(D_DEPTH+1) : 1)-1:0] d_count
);

    localparam int AB = 7 + SZW + SRCW + AW + DW/8 + DW;
    localparam int DB = 7 + SZW + SRCW + DW;
    localparam int CA = (A_DEPTH > 0) ? $clog2(A_DEPTH + 1) : 1;
    localparam int CD = (D_DEPTH > 0) ? $clog2(D_DEPTH + 1) : 1;

    tl_ul_queue #(
        .W     (AB),
        .DEPTH (A_DEPTH),
        .FLOW  (A_FLOW),
        .PIPE  (A_PIPE),
        .CW    (CA)
    ) u_a_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_in_valid  (a_in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_bits   (a_in_bits),
        .o_out_valid (a_out_valid),
        .i_out_ready (a_out_ready),
        .o_out_bits  (a_out_bits),
        .o_count     (a_count)
    );

    tl_ul_queue #(
        .W     (DB),
        .DEPTH (D_DEPTH),
        .FLOW  (D_FLOW),
        .PIPE  (D_PIPE),
        .CW    (CD)
    ) u_d_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_in_valid  (d_in_valid),
        .o_in_ready  (d_in_ready),
        .i_in_bits   (d_in_bits),
        .o_out_valid (d_out_valid),
        .i_out_ready (d_out_ready),
        .o_out_bits  (d_out_bits),
        .o_count     (d_count)
    );

endmodule
